assertion_result_collector: RTL and testbench

//  Downstream of the SVA-generated checker FSMs: takes each checker's

---
 rtl/assertion_result_collector_pkg.sv | 21 ++
 rtl/assertion_evt_fifo.sv | 45 ++++
 rtl/assertion_result_collector.sv | 116 +++++++++++
 tb/tb_assertion_result_collector.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/assertion_result_collector_pkg.sv
// assertion_collector_pkg: shared event type and bit-vector helpers for the collector
package assertion_collector_pkg;
   localparam int MAX_CHK = 32;
   localparam int CHK_IDX_W = 2;
   typedef struct packed {
      logic [CHK_IDX_W-1:0] id;
      logic [31:0]          ts;
   } evt_t;
   function automatic int unsigned lowest_idx(input logic [MAX_CHK-1:0] v);
      int unsigned r;
      r = 0;
      for (int i = MAX_CHK - 1; i >= 0; i--) r = v[i] ? i : r;
      return r;
   endfunction
   function automatic int unsigned popcount(input logic [MAX_CHK-1:0] v);
      int unsigned r;
      r = 0;
      for (int i = 0; i < MAX_CHK; i++) r = r + int'(v[i]);
      return r;
   endfunction
endpackage

// File: rtl/assertion_evt_fifo.sv
// assertion_evt_fifo: show-ahead sync FIFO with flush and push-while-full-with-pop
module assertion_evt_fifo #(
   parameter int W     = 34,
   parameter int DEPTH = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         flush,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);
   logic [AW:0]  wptr_q, rptr_q;
   logic [W-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;
   // status flags, accepted handshakes and head data (zero while empty)
   always_comb begin
      empty   = wptr_q == rptr_q;
      full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
      do_pop  = pop && !empty;
      do_push = push && (!full || do_pop);
      dout    = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   end
   // pointer update; flush wins over any handshake
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else if (flush) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_q + (AW+1)'(do_push);
         rptr_q <= rptr_q + (AW+1)'(do_pop);
      end
   end
   // storage write; the slot being read when full is overwritten only after the edge
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem_q[wptr_q[AW-1:0]] <= din;
   end
endmodule

// File: rtl/assertion_result_collector.sv
// assertion_result_collector: per-checker pass/fail stats, first-fail capture and failure event queue
module assertion_result_collector
   import assertion_collector_pkg::*;
#(
   parameter int NUM_CHK    = 4,
   parameter int CNT_W      = 16,
   parameter int TS_W       = 32,
   parameter int FIFO_DEPTH = 8,
   localparam int IW        = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_CHK-1:0] chk_pass,
   input  logic [NUM_CHK-1:0] chk_fail,
   input  logic [NUM_CHK-1:0] chk_active,
   input  logic               clear,
   input  logic [IW-1:0]      rd_sel,
   output logic [CNT_W-1:0]   rd_pass_cnt,
   output logic [CNT_W-1:0]   rd_fail_cnt,
   output logic               any_active,
   output logic               fail_sticky,
   output logic [IW-1:0]      first_fail_id,
   output logic [TS_W-1:0]    first_fail_ts,
   output logic               proto_err,
   output logic               evt_valid,
   input  logic               evt_ready,
   output logic [IW-1:0]      evt_id,
   output logic [TS_W-1:0]    evt_ts,
   output logic [CNT_W-1:0]   evt_drop_cnt
);
   localparam int SW = CNT_W + 7;
   logic [TS_W-1:0]    ts_q;
   logic [CNT_W-1:0]   pass_q [NUM_CHK];
   logic [CNT_W-1:0]   fail_q [NUM_CHK];
   logic [CNT_W-1:0]   drop_q, drop_d;
   logic               any_active_q, fail_sticky_q, proto_err_q;
   logic [IW-1:0]      ff_id_q;
   logic [TS_W-1:0]    ff_ts_q;
   logic [IW-1:0]      low_id;
   logic [SW-1:0]      drop_sum;
   logic               push, pop, full, empty;
   logic [IW+TS_W-1:0] head;
   // priority encode, handshakes and saturating drop accounting
   always_comb begin
      low_id   = IW'(lowest_idx(MAX_CHK'(chk_fail)));
      push     = |chk_fail && !clear;
      pop      = evt_ready && !empty;
      drop_sum = SW'(drop_q) + SW'(popcount(MAX_CHK'(chk_fail))) - SW'(|chk_fail)
               + SW'(push && full && !pop);
      drop_d   = clear ? '0 : (drop_sum > SW'({CNT_W{1'b1}}) ? '1 : drop_sum[CNT_W-1:0]);
   end
   // per-checker saturating pass/fail counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CHK; i++) begin
            pass_q[i] <= '0;
            fail_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_CHK; i++) begin
            pass_q[i] <= clear ? '0 : pass_q[i] + CNT_W'(chk_pass[i] && !(&pass_q[i]));
            fail_q[i] <= clear ? '0 : fail_q[i] + CNT_W'(chk_fail[i] && !(&fail_q[i]));
         end
      end
   end
   // timestamp, activity, sticky flags and first-fail capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_q          <= '0;
         any_active_q  <= 1'b0;
         drop_q        <= '0;
         fail_sticky_q <= 1'b0;
         proto_err_q   <= 1'b0;
         ff_id_q       <= '0;
         ff_ts_q       <= '0;
      end else begin
         ts_q         <= ts_q + TS_W'(1);
         any_active_q <= |chk_active;
         drop_q       <= drop_d;
         if (clear) begin
            fail_sticky_q <= 1'b0;
            proto_err_q   <= 1'b0;
            ff_id_q       <= '0;
            ff_ts_q       <= '0;
         end else begin
            proto_err_q <= proto_err_q | (|(chk_pass & chk_fail));
            if (!fail_sticky_q && |chk_fail) begin
               fail_sticky_q <= 1'b1;
               ff_id_q       <= low_id;
               ff_ts_q       <= ts_q;
            end
         end
      end
   end
   assertion_evt_fifo #(.W(IW + TS_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .flush (clear),
      .push  (push),
      .din   ({low_id, ts_q}),
      .pop   (evt_ready),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );
   assign rd_pass_cnt   = pass_q[rd_sel];
   assign rd_fail_cnt   = fail_q[rd_sel];
   assign any_active    = any_active_q;
   assign fail_sticky   = fail_sticky_q;
   assign first_fail_id = ff_id_q;
   assign first_fail_ts = ff_ts_q;
   assign proto_err     = proto_err_q;
   assign evt_valid     = !empty;
   assign {evt_id, evt_ts} = head;
   assign evt_drop_cnt  = drop_q;
endmodule

// File: tb/tb_assertion_result_collector.sv
// tb_assertion_result_collector: table vectors plus event scoreboard for the result collector
module tb_assertion_result_collector;
   logic        clk = 1'b0, rst = 1'b1, clear = 1'b0, evt_ready = 1'b0;
   logic [3:0]  chk_pass = '0, chk_fail = '0, chk_active = '0;
   logic [1:0]  rd_sel = '0;
   logic [15:0] rd_pass_cnt, rd_fail_cnt, evt_drop_cnt;
   logic        any_active, fail_sticky, proto_err, evt_valid;
   logic [1:0]  first_fail_id, evt_id;
   logic [31:0] first_fail_ts, evt_ts;
   logic [3:0]  d4_pass, d4_fail, d4_drop;
   logic        d4_act, d4_sticky, d4_proto, d4_valid;
   logic [1:0]  d4_ffid, d4_id;
   logic [31:0] d4_ffts, d4_ts;
   int          checks = 0, errors = 0;
   logic [31:0] tb_ts;
   typedef struct {logic [1:0] id; logic [31:0] ts;} sb_t;
   sb_t exp_q[$];
   typedef struct {
      logic [3:0] pass, fail;
      logic       ready, clr;
      int         n;
      logic [1:0] sel;
      int         ep, ef;
      logic       eproto;
      int         edrop;
      logic       esticky;
   } vec_t;
   vec_t vt[5];

   assertion_result_collector dut (
      .clk(clk), .rst(rst), .chk_pass(chk_pass), .chk_fail(chk_fail), .chk_active(chk_active),
      .clear(clear), .rd_sel(rd_sel), .rd_pass_cnt(rd_pass_cnt), .rd_fail_cnt(rd_fail_cnt),
      .any_active(any_active), .fail_sticky(fail_sticky), .first_fail_id(first_fail_id),
      .first_fail_ts(first_fail_ts), .proto_err(proto_err), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .evt_id(evt_id), .evt_ts(evt_ts), .evt_drop_cnt(evt_drop_cnt)
   );
   assertion_result_collector #(.CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .chk_pass(chk_pass), .chk_fail(chk_fail), .chk_active(chk_active),
      .clear(clear), .rd_sel(rd_sel), .rd_pass_cnt(d4_pass), .rd_fail_cnt(d4_fail),
      .any_active(d4_act), .fail_sticky(d4_sticky), .first_fail_id(d4_ffid),
      .first_fail_ts(d4_ffts), .proto_err(d4_proto), .evt_valid(d4_valid),
      .evt_ready(evt_ready), .evt_id(d4_id), .evt_ts(d4_ts), .evt_drop_cnt(d4_drop)
   );

   always #5 clk = ~clk;
   always @(posedge clk or posedge rst) tb_ts <= rst ? 32'd0 : tb_ts + 32'd1;

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // drive one cycle from a negedge; scoreboard predicts queue contents and checks pops
   task automatic step(input logic [3:0] p, input logic [3:0] f, input logic r, input logic c);
      int  sz;
      bit  popd;
      sb_t e;
      chk_pass = p; chk_fail = f; evt_ready = r; clear = c;
      sz = exp_q.size();
      check("evt_valid", evt_valid, sz != 0);
      popd = r && sz != 0;
      if (c) exp_q.delete();
      else begin
         if (popd) begin
            check("evt_id", evt_id, exp_q[0].id);
            check("evt_ts", evt_ts, exp_q[0].ts);
            void'(exp_q.pop_front());
         end
         if (f != 0 && (sz < 8 || popd)) begin
            e.ts = tb_ts;
            e.id = f[0] ? 2'd0 : f[1] ? 2'd1 : f[2] ? 2'd2 : 2'd3;
            exp_q.push_back(e);
         end
      end
      @(posedge clk);
      @(negedge clk);
      chk_pass = '0; chk_fail = '0; clear = 1'b0;
   endtask

   initial begin
      vt[0] = '{4'b0100, 4'b0000, 1'b1, 1'b0,  5, 2'd2,  5, 0, 1'b0, 1, 1'b1};
      vt[1] = '{4'b0001, 4'b0000, 1'b1, 1'b0, 20, 2'd0, 20, 0, 1'b0, 1, 1'b1};
      vt[2] = '{4'b1000, 4'b1000, 1'b1, 1'b0,  1, 2'd3,  1, 2, 1'b1, 1, 1'b1};
      vt[3] = '{4'b0000, 4'b0000, 1'b1, 1'b0,  1, 2'd3,  1, 2, 1'b1, 1, 1'b1};
      vt[4] = '{4'b0000, 4'b0001, 1'b0, 1'b1,  1, 2'd0,  0, 0, 1'b0, 0, 1'b0};
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_valid", evt_valid, 0);
      check("rst_drop", evt_drop_cnt, 0);
      check("rst_sticky", fail_sticky, 0);
      check("rst_proto", proto_err, 0);
      check("rst_pass", rd_pass_cnt, 0);
      check("rst_active", any_active, 0);
      for (int k = 0; k < 50 && tb_ts != 32'd10; k++) step(4'b0, 4'b0, 1'b0, 1'b0);
      step(4'b0000, 4'b1010, 1'b0, 1'b0);
      check("ff_id", first_fail_id, 1);
      check("ff_ts", first_fail_ts, 10);
      check("drop_multi", evt_drop_cnt, 1);
      for (int i = 0; i < 5; i++) begin
         rd_sel = vt[i].sel;
         for (int k = 0; k < vt[i].n; k++) step(vt[i].pass, vt[i].fail, vt[i].ready, vt[i].clr);
         check($sformatf("v%0d_pass", i), rd_pass_cnt, vt[i].ep);
         check($sformatf("v%0d_fail", i), rd_fail_cnt, vt[i].ef);
         check($sformatf("v%0d_proto", i), proto_err, vt[i].eproto);
         check($sformatf("v%0d_drop", i), evt_drop_cnt, vt[i].edrop);
         check($sformatf("v%0d_sticky", i), fail_sticky, vt[i].esticky);
         if (i == 1) check("sat_cnt4", d4_pass, 15);
      end
      check("clr_ffid", first_fail_id, 0);
      check("clr_ffts", first_fail_ts, 0);
      repeat (9) step(4'b0000, 4'b0001, 1'b0, 1'b0);
      check("full_drop", evt_drop_cnt, 1);
      step(4'b0000, 4'b0001, 1'b1, 1'b0);
      check("full_pop_drop", evt_drop_cnt, 1);
      repeat (8) step(4'b0, 4'b0, 1'b1, 1'b0);
      step(4'b0, 4'b0, 1'b1, 1'b0);
      repeat (3) step(4'b0000, 4'b0001, 1'b0, 1'b0);
      rd_sel = 2'd0;
      check("pre_rst_fail", rd_fail_cnt, 13);
      check("pre_rst_valid", evt_valid, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", evt_valid, 0);
      check("arst_fail", rd_fail_cnt, 0);
      check("arst_sticky", fail_sticky, 0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      repeat (2) step(4'b0, 4'b0, 1'b0, 1'b0);
      step(4'b0000, 4'b0100, 1'b0, 1'b0);
      check("ts_restart", first_fail_ts, 2);
      check("ts_restart_id", first_fail_id, 2);
      chk_active = 4'b0100;
      step(4'b0, 4'b0, 1'b1, 1'b0);
      check("any_active_hi", any_active, 1);
      chk_active = 4'b0000;
      step(4'b0, 4'b0, 1'b0, 1'b0);
      check("any_active_lo", any_active, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
